// File: rtl/fixed_mac_feeder_if.sv
// rtl/fixed_mac_feeder_if.sv - A/B operand streams and result stream between the feeder and fixed_mac
interface fixed_mac_feeder_if #(
    parameter int WI1 = 4,
    parameter int WF1 = 8,
    parameter int WI2 = 3,
    parameter int WF2 = 5,
    parameter int WIO = 15,
    parameter int WFO = 30
);
    logic [WI1+WF1-1:0] A_data;
    logic               A_valid;
    logic               A_ready;
    logic               A_last;
    logic [WI2+WF2-1:0] B_data;
    logic               B_valid;
    logic               B_ready;
    logic               B_last;
    logic [WIO+WFO-1:0] res_data;
    logic               res_valid;
    logic               res_ready;
    logic               res_last;
    logic               mac_overflow;
    logic               mac_underflow;

    // Feeder side: sources both operand streams, sinks the result.
    modport master (
        output A_data, A_valid, A_last,
        output B_data, B_valid, B_last,
        output res_ready,
        input  A_ready, B_ready,
        input  res_data, res_valid, res_last, mac_overflow, mac_underflow
    );

    // MAC side: sinks both operand streams, sources the result.
    modport slave (
        input  A_data, A_valid, A_last,
        input  B_data, B_valid, B_last,
        input  res_ready,
        output A_ready, B_ready,
        output res_data, res_valid, res_last, mac_overflow, mac_underflow
    );
endinterface

// File: rtl/fixed_mac_feeder.sv
// rtl/fixed_mac_feeder.sv - operand buffer, A/B stream source and result sink for fixed_mac (optional watchdog: FIXED_MAC_FEEDER_TIMEOUT_EN)
module fixed_mac_feeder #(
    parameter int WI1    = 4,
    parameter int WF1    = 8,
    parameter int WI2    = 3,
    parameter int WF2    = 5,
    parameter int WIO    = 15,
    parameter int WFO    = 30,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH),
    parameter int TO_CYC = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WI1+WF1-1:0]  wr_a,
    input  logic [WI2+WF2-1:0]  wr_b,
    input  logic                start,
    input  logic [AW:0]         len,
    fixed_mac_feeder_if.master  mac,
    output logic [WIO+WFO-1:0]  result,
    output logic                ovf_flag,
    output logic                unf_flag,
    output logic                busy,
    output logic                done,
    output logic                error
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_RES, S_DONE} state_t;

    state_t             state;
    logic [WI1+WF1-1:0] buf_a [DEPTH];
    logic [WI2+WF2-1:0] buf_b [DEPTH];
    logic [AW:0]        len_r;
    logic [AW:0]        a_idx;
    logic [AW:0]        b_idx;
    logic               a_valid_r;
    logic               b_valid_r;
    logic               a_last_r;
    logic               b_last_r;
    logic               res_ready_r;

    logic [AW:0]        a_nxt;
    logic [AW:0]        b_nxt;
    logic [AW:0]        len_m1;
    logic               len_ok;
    logic               a_hs;
    logic               b_hs;
    logic               r_hs;

    assign a_nxt  = a_idx + (AW+1)'(1);
    assign b_nxt  = b_idx + (AW+1)'(1);
    assign len_m1 = len_r - (AW+1)'(1);
    assign len_ok = (len != '0) && (len <= (AW+1)'(DEPTH));
    assign a_hs   = a_valid_r && mac.A_ready;
    assign b_hs   = b_valid_r && mac.B_ready;
    assign r_hs   = res_ready_r && mac.res_valid;

    // Data is read straight from the buffer at the registered index, so it
    // cannot change while a beat is stalled (the buffer is frozen outside IDLE).
    assign mac.A_data    = buf_a[a_idx[AW-1:0]];
    assign mac.B_data    = buf_b[b_idx[AW-1:0]];
    assign mac.A_valid   = a_valid_r;
    assign mac.B_valid   = b_valid_r;
    assign mac.A_last    = a_last_r;
    assign mac.B_last    = b_last_r;
    assign mac.res_ready = res_ready_r;

    // The first valid result beat is the answer; res_last carries no meaning here.
    logic unused_res_last;
    assign unused_res_last = mac.res_last;

    // Host writes into the operand buffer, accepted only while idle.
    always_ff @(posedge clk) begin
        if (wr_en && state == S_IDLE) begin
            buf_a[wr_addr] <= wr_a;
            buf_b[wr_addr] <= wr_b;
        end
    end

`ifdef FIXED_MAC_FEEDER_TIMEOUT_EN
    localparam int WDW = $clog2(TO_CYC + 1);
    logic [WDW-1:0] wd_cnt;
`else
    localparam int unused_to_cyc = TO_CYC;
`endif

    // Control FSM: start/len check, independent A/B stream indices, result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            len_r       <= '0;
            a_idx       <= '0;
            b_idx       <= '0;
            a_valid_r   <= 1'b0;
            b_valid_r   <= 1'b0;
            a_last_r    <= 1'b0;
            b_last_r    <= 1'b0;
            res_ready_r <= 1'b0;
            result      <= '0;
            ovf_flag    <= 1'b0;
            unf_flag    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef FIXED_MAC_FEEDER_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_r     <= len;
                            a_idx     <= '0;
                            b_idx     <= '0;
                            a_valid_r <= 1'b1;
                            b_valid_r <= 1'b1;
                            a_last_r  <= (len == (AW+1)'(1));
                            b_last_r  <= (len == (AW+1)'(1));
                            busy      <= 1'b1;
                            state     <= S_STREAM;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (a_hs) begin
                        a_idx     <= a_nxt;
                        a_valid_r <= (a_nxt < len_r);
                        a_last_r  <= (a_nxt == len_m1);
                    end
                    if (b_hs) begin
                        b_idx     <= b_nxt;
                        b_valid_r <= (b_nxt < len_r);
                        b_last_r  <= (b_nxt == len_m1);
                    end
                    // Both valids already low means both channels have finished.
                    if (!a_valid_r && !b_valid_r) begin
                        res_ready_r <= 1'b1;
                        state       <= S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    if (mac.res_valid) begin
                        result      <= mac.res_data;
                        ovf_flag    <= mac.mac_overflow;
                        unf_flag    <= mac.mac_underflow;
                        res_ready_r <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
`ifdef FIXED_MAC_FEEDER_TIMEOUT_EN
            // Watchdog: any handshake restarts the count; expiry aborts to IDLE
            // without touching the captured result.
            if (state == S_STREAM || state == S_WAIT_RES) begin
                if (a_hs || b_hs || r_hs) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == WDW'(TO_CYC - 1)) begin
                    wd_cnt      <= '0;
                    error       <= 1'b1;
                    a_valid_r   <= 1'b0;
                    b_valid_r   <= 1'b0;
                    a_last_r    <= 1'b0;
                    b_last_r    <= 1'b0;
                    res_ready_r <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end else begin
                    wd_cnt <= wd_cnt + WDW'(1);
                end
            end else begin
                wd_cnt <= '0;
            end
`else
            if (r_hs && state != S_WAIT_RES) begin
                res_ready_r <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fixed_mac_feeder.sv
// tb/tb_fixed_mac_feeder.sv - directed self-checking bench for fixed_mac_feeder
module tb_fixed_mac_feeder;
    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_a;
    logic [7:0]  wr_b;
    logic        start;
    logic [4:0]  len;
    logic [44:0] result;
    logic        ovf_flag;
    logic        unf_flag;
    logic        busy;
    logic        done;
    logic        error;

    int total;
    int passed;

    logic [11:0] va [3];
    logic [7:0]  vb [3];

    fixed_mac_feeder_if mac_if ();

    fixed_mac_feeder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_a     (wr_a),
        .wr_b     (wr_b),
        .start    (start),
        .len      (len),
        .mac      (mac_if),
        .result   (result),
        .ovf_flag (ovf_flag),
        .unf_flag (unf_flag),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [11:0] a, input logic [7:0] b);
        wr_en = 1'b1; wr_addr = addr; wr_a = a; wr_b = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_vectors();
        for (int i = 0; i < 3; i++) wr(4'(i), va[i], vb[i]);
    endtask

    function automatic logic [9:0] ctl();
        return {mac_if.A_valid, mac_if.A_last, mac_if.B_valid, mac_if.B_last,
                mac_if.res_ready, busy, done, error, ovf_flag, unf_flag};
    endfunction

    initial begin
        int ai;
        int bi;
        total = 0; passed = 0;
        va[0] = 12'h100; va[1] = 12'h200; va[2] = 12'hF80;
        vb[0] = 8'h10;   vb[1] = 8'h08;   vb[2] = 8'h40;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
        start = 1'b0; len = '0;
        mac_if.A_ready = 1'b0; mac_if.B_ready = 1'b0;
        mac_if.res_data = '0; mac_if.res_valid = 1'b0; mac_if.res_last = 1'b0;
        mac_if.mac_overflow = 1'b0; mac_if.mac_underflow = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_ctl", 64'(ctl()), 64'h0);
        check("reset_result", 64'(result), 64'h0);
        tick();
        reset_n = 1'b1;
        tick();
        load_vectors();

        // Test 1: readies high, three beats, result capture
        mac_if.A_ready = 1'b1; mac_if.B_ready = 1'b1;
        start = 1'b1; len = 5'd3;
        tick();
        start = 1'b0;
        check("t1_busy", 64'(busy), 64'h1);
        for (int i = 0; i < 3; i++) begin
            check("t1_a_valid", 64'(mac_if.A_valid), 64'h1);
            check("t1_a_data", 64'(mac_if.A_data), 64'(va[i]));
            check("t1_a_last", 64'(mac_if.A_last), 64'(i == 2));
            check("t1_b_valid", 64'(mac_if.B_valid), 64'h1);
            check("t1_b_data", 64'(mac_if.B_data), 64'(vb[i]));
            check("t1_b_last", 64'(mac_if.B_last), 64'(i == 2));
            tick();
        end
        check("t1_post_stream", 64'({mac_if.A_valid, mac_if.B_valid, mac_if.res_ready, busy}), 64'h1);
        tick();
        check("t1_res_ready", 64'(mac_if.res_ready), 64'h1);
        mac_if.res_data = 45'h0123_4567_89AB; mac_if.res_valid = 1'b1;
        tick();
        mac_if.res_valid = 1'b0;
        check("t1_done", 64'({done, busy, mac_if.res_ready}), 64'h6);
        check("t1_result", 64'(result), 64'h0123_4567_89AB);
        check("t1_flags", 64'({ovf_flag, unf_flag}), 64'h0);
        tick();
        check("t1_idle", 64'({done, busy}), 64'h0);

        // Test 2: A_ready toggles, B_ready high; B finishes first
        ai = 0; bi = 0;
        start = 1'b1; len = 5'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mac_if.A_ready = (k % 2 == 0);
            if (k == 1) begin
                wr_en = 1'b1; wr_addr = 4'd0; wr_a = 12'hABC; wr_b = 8'hCD;
            end
            check("t2_a_valid", 64'(mac_if.A_valid), 64'(ai < 3));
            check("t2_b_valid", 64'(mac_if.B_valid), 64'(bi < 3));
            if (ai < 3) begin
                check("t2_a_data", 64'(mac_if.A_data), 64'(va[ai]));
                check("t2_a_last", 64'(mac_if.A_last), 64'(ai == 2));
            end
            if (bi < 3) check("t2_b_data", 64'(mac_if.B_data), 64'(vb[bi]));
            check("t2_no_res_ready", 64'(mac_if.res_ready), 64'h0);
            tick();
            wr_en = 1'b0;
            if (mac_if.A_ready && ai < 3) ai++;
            if (bi < 3) bi++;
        end
        mac_if.A_ready = 1'b1;
        check("t2_res_ready", 64'(mac_if.res_ready), 64'h1);
        mac_if.res_data = 45'h1ABC_DEF0_1234; mac_if.res_valid = 1'b1;
        mac_if.mac_underflow = 1'b1;
        tick();
        mac_if.res_valid = 1'b0; mac_if.mac_underflow = 1'b0;
        check("t2_done", 64'(done), 64'h1);
        check("t2_result", 64'(result), 64'h1ABC_DEF0_1234);
        check("t2_flags", 64'({ovf_flag, unf_flag}), 64'h1);
        tick();

        // Test 3: illegal lengths
        start = 1'b1; len = 5'd0;
        tick();
        start = 1'b0;
        check("t3_len0", 64'({error, busy, mac_if.A_valid, mac_if.B_valid}), 64'h8);
        tick();
        check("t3_len0_pulse", 64'(error), 64'h0);
        start = 1'b1; len = 5'd17;
        tick();
        start = 1'b0;
        check("t3_len17", 64'({error, busy, mac_if.A_valid, mac_if.B_valid}), 64'h8);
        tick();
        check("t3_len17_idle", 64'({error, busy, mac_if.A_valid}), 64'h0);
        check("t3_result_held", 64'(result), 64'h1ABC_DEF0_1234);

        // Test 4: len=1, overflow captured; buffer untouched by busy-time write
        start = 1'b1; len = 5'd1;
        tick();
        start = 1'b0;
        check("t4_beat", 64'({mac_if.A_valid, mac_if.A_last, mac_if.B_valid, mac_if.B_last}), 64'hF);
        check("t4_a_data", 64'(mac_if.A_data), 64'h100);
        check("t4_b_data", 64'(mac_if.B_data), 64'h10);
        tick();
        check("t4_after", 64'({mac_if.A_valid, mac_if.B_valid}), 64'h0);
        tick();
        mac_if.res_data = 45'h42; mac_if.res_valid = 1'b1; mac_if.mac_overflow = 1'b1;
        tick();
        mac_if.res_valid = 1'b0; mac_if.mac_overflow = 1'b0;
        check("t4_done", 64'(done), 64'h1);
        check("t4_result", 64'(result), 64'h42);
        check("t4_flags", 64'({ovf_flag, unf_flag}), 64'h2);
        tick();

        // Test 5: asynchronous reset mid-stream, then restart from index 0
        mac_if.A_ready = 1'b0; mac_if.B_ready = 1'b0;
        start = 1'b1; len = 5'd3;
        tick();
        start = 1'b0;
        mac_if.A_ready = 1'b1;
        tick();
        mac_if.A_ready = 1'b0;
        check("t5_mid", 64'(mac_if.A_data), 64'h200);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_ctl", 64'(ctl()), 64'h0);
        check("t5_async_result", 64'(result), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        load_vectors();
        mac_if.A_ready = 1'b1; mac_if.B_ready = 1'b1;
        start = 1'b1; len = 5'd3;
        tick();
        start = 1'b0;
        check("t5_restart_a", 64'(mac_if.A_data), 64'h100);
        check("t5_restart_b", 64'(mac_if.B_data), 64'h10);
        check("t5_restart_valid", 64'({mac_if.A_valid, busy}), 64'h3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fixed_mac_feeder.md
Name: fixed_mac_feeder

Overview:
Stream source and result sink for fixed_mac. It holds paired A/B operand vectors in a small internal buffer, loaded through a simple write port. On start it transmits them on the A and B valid/ready/last channels, then accepts the accumulated result from the MAC's out channel. The result and the MAC overflow/underflow flags are captured for the host, and completion is signalled with a done pulse.

Parameters:
WI1, 4, integer bits of A operand
WF1, 8, fractional bits of A operand
WI2, 3, integer bits of B operand
WF2, 5, fractional bits of B operand
WIO, 15, integer bits of result
WFO, 30, fractional bits of result
DEPTH, 16, vector buffer entries (power of 2, >=2)
AW, $clog2(DEPTH), buffer address width
TO_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer write address
wr_a  in  WI1+WF1  A operand to store
wr_b  in  WI2+WF2  B operand to store
start  in  1  begin a transfer (sampled in IDLE only)
len  in  AW+1  element count, legal range 1..DEPTH
A_data  out  WI1+WF1  A stream data
A_valid  out  1  A stream valid
A_ready  in  1  A stream ready
A_last  out  1  marks final A element
B_data  out  WI2+WF2  B stream data
B_valid  out  1  B stream valid
B_ready  in  1  B stream ready
B_last  out  1  marks final B element
res_data  in  WIO+WFO  MAC result
res_valid  in  1  result valid
res_ready  out  1  result ready
res_last  in  1  result last
mac_overflow  in  1  MAC overflow flag
mac_underflow  in  1  MAC underflow flag
result  out  WIO+WFO  captured result
ovf_flag  out  1  overflow flag captured with the result
unf_flag  out  1  underflow flag captured with the result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
error  out  1  one-cycle pulse on illegal start or watchdog expiry

Behaviour:
- Reset (asynchronous assert, synchronous deassert release):
  - state=IDLE.
  - A_valid, B_valid, A_last, B_last, res_ready, done, error, busy = 0.
  - result, ovf_flag, unf_flag = 0.
  - Buffer contents are undefined.
- Buffer write: when wr_en=1 and state=IDLE, the pair (wr_a, wr_b) is written at wr_addr. wr_en in any other state is ignored.
- FSM states: IDLE, STREAM, WAIT_RES, DONE.
- IDLE:
  - start=1 with 1<=len<=DEPTH: latch len, clear a_idx and b_idx, go to STREAM.
  - start=1 with len=0 or len>DEPTH: error=1 for one cycle, remain in IDLE.
- STREAM:
  - A_valid=1 while a_idx<len. A_data=buf_a[a_idx]. A_last=(a_idx==len-1).
  - A handshake: a_idx increments on A_valid&&A_ready.
  - B channel is identical and independent, using b_idx.
  - A channel drops A_valid the cycle after its last handshake; B likewise.
  - Data and last stay stable while valid is high and ready is low. Valid is never withdrawn before its handshake.
  - Channels may complete in either order. Transition to WAIT_RES once both have completed; simultaneous final handshakes transition on the next cycle.
- WAIT_RES:
  - res_ready=1.
  - On res_valid: capture res_data into result, mac_overflow into ovf_flag, mac_underflow into unf_flag, then go to DONE.
  - res_last is ignored for capture; the first valid beat is the result.
- DONE: done=1 for exactly one cycle, then IDLE. result and flags hold until the next capture or reset.
- Latency:
  - With A_ready and B_ready held high, transfer of len elements takes len cycles.
  - busy rises the cycle after start is accepted.
- start asserted while busy is ignored.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
- Macro: FIXED_MAC_FEEDER_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in STREAM and WAIT_RES and resets on every handshake of either channel or the result.
  - When the counter reaches TO_CYC: error=1 for one cycle, all valids and res_ready drop, state returns to IDLE, and result is unchanged.
- When not defined: no counter is built, and the block can wait indefinitely for ready or res_valid.

Test Plan:
- Load A={0x100,0x200,0xF80}, B={0x10,0x08,0x40}, len=3, readies held high. Expect A and B beats in cycles 1-3 after busy rises, with *_last only on the third beat. Then drive res_data=0x...; result matches, done pulses once.
- Same vectors, A_ready toggling 1,0,1,0 and B_ready held high. Expect A_data stable during stalls and B completing first. WAIT_RES is entered only after the third A handshake.
- start with len=0, then with len=17 (DEPTH=16). Expect an error pulse each time, busy stays 0, and no valid is asserted.
- len=1. Expect A_last=B_last=1 on the single beat. A result with mac_overflow=1 sets ovf_flag=1.
- Deassert reset_n while in STREAM mid-vector. Expect all outputs at reset values immediately, asynchronously. A new start after release restarts from index 0.
- With FIXED_MAC_FEEDER_TIMEOUT_EN and TO_CYC=8: hold res_valid=0. Expect an error pulse 8 cycles after the last stream handshake, return to IDLE, and result unchanged.
